// File: rtl/alu_dispatch_pkg.sv
// Shared opcode / function-code constants and small decode helpers for the ALU dispatcher.
package alu_dispatch_pkg;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SR  = 3'b101;

    localparam logic [6:0] F7_ZERO = 7'b0000000;

    function automatic logic is_shift(input logic [2:0] fun3);
        return (fun3 == F3_SLL) || (fun3 == F3_SR);
    endfunction

    function automatic logic is_legal(input logic [6:0] opcode);
        return (opcode == OPC_OP) || (opcode == OPC_OPIMM);
    endfunction

endpackage

// File: rtl/alu_operand_sel.sv
// Combinational operand former: picks rs2 vs immediate, derives fun7 and masks shift amounts.
module alu_operand_sel
    import alu_dispatch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [6:0]      opcode_i,
    input  logic [2:0]      fun3_i,
    input  logic [6:0]      fun7_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [XLEN-1:0] imm_i,
    output logic [6:0]      fun7_o,
    output logic [XLEN-1:0] rs2_o,
    output logic            legal_o
);

    logic [XLEN-1:0] raw_rs2;

    always_comb begin
        raw_rs2 = rs2_i;
        fun7_o  = fun7_i;
        if (opcode_i == OPC_OPIMM) begin
            raw_rs2 = imm_i;
            // Only SRLI/SRAI carry a meaningful fun7, taken from the upper immediate bits.
            fun7_o  = (fun3_i == F3_SR) ? imm_i[11:5] : F7_ZERO;
        end
        rs2_o = is_shift(fun3_i) ? {{(XLEN-5){1'b0}}, raw_rs2[4:0]} : raw_rs2;
    end

    assign legal_o = is_legal(opcode_i);

endmodule

// File: rtl/alu_dispatch.sv
// Execute-stage dispatcher: latches one OP/OP-IMM instruction, drives the ALU start/busy/done
// handshake with a WAIT timeout, and holds the result for writeback until accepted.
module alu_dispatch
    import alu_dispatch_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [6:0]      in_opcode_i,
    input  logic [2:0]      in_fun3_i,
    input  logic [6:0]      in_fun7_i,
    input  logic [XLEN-1:0] in_rs1_i,
    input  logic [XLEN-1:0] in_rs2_i,
    input  logic [XLEN-1:0] in_imm_i,
    input  logic [4:0]      in_rd_i,
    output logic            alu_start_o,
    output logic [2:0]      alu_fun3_o,
    output logic [6:0]      alu_fun7_o,
    output logic [XLEN-1:0] alu_rs1_o,
    output logic [XLEN-1:0] alu_rs2_o,
    input  logic            alu_busy_i,
    input  logic            alu_done_i,
    input  logic [XLEN-1:0] alu_res_i,
    input  logic            alu_zero_i,
    input  logic            alu_neg_i,
    output logic            wb_valid_o,
    input  logic            wb_ready_i,
    output logic            wb_we_o,
    output logic [4:0]      wb_rd_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic            wb_zero_o,
    output logic            wb_neg_o,
    output logic            wb_err_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_WB    = 2'd3;

    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      fun3_q;
    logic [6:0]      fun7_q;
    logic [XLEN-1:0] rs1_q, rs2_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] wb_data_q;
    logic            wb_we_q, wb_zero_q, wb_neg_q, wb_err_q;

    logic [6:0]      sel_fun7;
    logic [XLEN-1:0] sel_rs2;
    logic            sel_legal;
    logic            accept;
    logic            timed_out;

    alu_operand_sel #(.XLEN(XLEN)) u_operand_sel (
        .opcode_i (in_opcode_i),
        .fun3_i   (in_fun3_i),
        .fun7_i   (in_fun7_i),
        .rs2_i    (in_rs2_i),
        .imm_i    (in_imm_i),
        .fun7_o   (sel_fun7),
        .rs2_o    (sel_rs2),
        .legal_o  (sel_legal)
    );

    assign accept    = in_valid_i && (state_q == S_IDLE);
    assign timed_out = (cnt_q == CNT_LAST);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid_i) state_d = sel_legal ? S_ISSUE : S_WB;
            S_ISSUE: if (!alu_busy_i) state_d = S_WAIT;
            S_WAIT:  if (alu_done_i || timed_out) state_d = S_WB;
            S_WB:    if (wb_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready_o  = (state_q == S_IDLE);
        alu_start_o = (state_q == S_ISSUE) && !alu_busy_i;
        wb_valid_o  = (state_q == S_WB);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q     <= '0;
            fun3_q    <= '0;
            fun7_q    <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            wb_data_q <= '0;
            wb_we_q   <= 1'b0;
            wb_zero_q <= 1'b0;
            wb_neg_q  <= 1'b0;
            wb_err_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (accept) begin
                    rd_q      <= in_rd_i;
                    wb_data_q <= '0;
                    wb_we_q   <= 1'b0;
                    wb_zero_q <= 1'b0;
                    wb_neg_q  <= 1'b0;
                    wb_err_q  <= !sel_legal;
                    if (sel_legal) begin
                        fun3_q <= in_fun3_i;
                        fun7_q <= sel_fun7;
                        rs1_q  <= in_rs1_i;
                        rs2_q  <= sel_rs2;
                    end
                end
                S_ISSUE: cnt_q <= '0;
                S_WAIT: begin
                    cnt_q <= cnt_q + CW'(1);
                    // A done arriving on the last allowed cycle still counts as success.
                    if (alu_done_i) begin
                        wb_data_q <= alu_res_i;
                        wb_zero_q <= alu_zero_i;
                        wb_neg_q  <= alu_neg_i;
                        wb_we_q   <= (rd_q != 5'd0);
                        wb_err_q  <= 1'b0;
                    end else if (timed_out) begin
                        wb_data_q <= '0;
                        wb_we_q   <= 1'b0;
                        wb_err_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign alu_fun3_o = fun3_q;
    assign alu_fun7_o = fun7_q;
    assign alu_rs1_o  = rs1_q;
    assign alu_rs2_o  = rs2_q;
    assign wb_we_o    = wb_we_q;
    assign wb_rd_o    = rd_q;
    assign wb_data_o  = wb_data_q;
    assign wb_zero_o  = wb_zero_q;
    assign wb_neg_o   = wb_neg_q;
    assign wb_err_o   = wb_err_q;

endmodule

// File: tb/tb_alu_dispatch.sv
// Randomized bench for alu_dispatch: emulates decode, the ALU and writeback, checks against a reference model.
module tb_alu_dispatch;

    localparam int XLEN    = 32;
    localparam int TIMEOUT = 16;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    logic            clk;
    logic            reset_i;
    logic            in_valid_i;
    logic            in_ready_o;
    logic [6:0]      in_opcode_i;
    logic [2:0]      in_fun3_i;
    logic [6:0]      in_fun7_i;
    logic [XLEN-1:0] in_rs1_i, in_rs2_i, in_imm_i;
    logic [4:0]      in_rd_i;
    logic            alu_start_o;
    logic [2:0]      alu_fun3_o;
    logic [6:0]      alu_fun7_o;
    logic [XLEN-1:0] alu_rs1_o, alu_rs2_o;
    logic            alu_busy_i, alu_done_i;
    logic [XLEN-1:0] alu_res_i;
    logic            alu_zero_i, alu_neg_i;
    logic            wb_valid_o, wb_ready_i, wb_we_o;
    logic [4:0]      wb_rd_o;
    logic [XLEN-1:0] wb_data_o;
    logic            wb_zero_o, wb_neg_o, wb_err_o;

    int total = 0;
    int bad   = 0;

    // Instruction being offered
    logic [6:0]  i_opc;
    logic [2:0]  i_f3;
    logic [6:0]  i_f7;
    logic [31:0] i_rs1, i_rs2, i_imm;
    logic [4:0]  i_rd;

    // Observations gathered by the driver
    int          obs_starts, obs_lat;
    bit          obs_got_wb, obs_busy_viol, obs_hold_bad, obs_stall_bad, obs_rdy_bad;
    bit          obs_post_rdy, obs_post_vld;
    logic [2:0]  obs_f3;
    logic [6:0]  obs_f7;
    logic [31:0] obs_rs1, obs_rs2;
    logic [31:0] obs_data;
    logic [4:0]  obs_rd;
    logic        obs_we, obs_zero, obs_neg, obs_err;

    alu_dispatch #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_opcode_i(in_opcode_i), .in_fun3_i(in_fun3_i), .in_fun7_i(in_fun7_i),
        .in_rs1_i(in_rs1_i), .in_rs2_i(in_rs2_i), .in_imm_i(in_imm_i), .in_rd_i(in_rd_i),
        .alu_start_o(alu_start_o), .alu_fun3_o(alu_fun3_o), .alu_fun7_o(alu_fun7_o),
        .alu_rs1_o(alu_rs1_o), .alu_rs2_o(alu_rs2_o),
        .alu_busy_i(alu_busy_i), .alu_done_i(alu_done_i), .alu_res_i(alu_res_i),
        .alu_zero_i(alu_zero_i), .alu_neg_i(alu_neg_i),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_we_o(wb_we_o),
        .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o), .wb_zero_o(wb_zero_o),
        .wb_neg_o(wb_neg_o), .wb_err_o(wb_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic bit m_legal(input logic [6:0] opc);
        return (opc == OPC_OP) || (opc == OPC_OPIMM);
    endfunction

    function automatic logic [31:0] m_rs2(input logic [6:0] opc, input logic [2:0] f3,
                                          input logic [31:0] rs2, input logic [31:0] imm);
        logic [31:0] b;
        b = (opc == OPC_OP) ? rs2 : imm;
        if (f3 == 3'd1 || f3 == 3'd5) b = b % 32;
        return b;
    endfunction

    function automatic logic [6:0] m_f7(input logic [6:0] opc, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic [31:0] imm);
        if (opc == OPC_OP) return f7;
        if (f3 == 3'd5) return 7'(imm >> 5);
        return 7'd0;
    endfunction

    function automatic logic [31:0] m_alu(input logic [2:0] f3, input logic [6:0] f7,
                                          input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (f3)
            3'd0: return (f7 == 7'h20) ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return (f7 == 7'h20) ? 32'($signed(a) >>> sh) : a >> sh;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    // ---------------- driver: offer one instruction, act as ALU and writeback ----------------
    // Enters and leaves at negedge+1. busy_n: cycles alu_busy is held after accept.
    // done_dly: WAIT cycles before alu_done (-1 = never). stall_n: cycles wb_ready stays low.
    task automatic do_op(input int busy_n, input int done_dly, input int stall_n);
        int cyc, wait_left;
        bit started;
        logic [31:0] alu_out;
        obs_starts = 0; obs_lat = 0; obs_got_wb = 0; obs_busy_viol = 0;
        obs_hold_bad = 0; obs_stall_bad = 0; obs_rdy_bad = 0;
        obs_post_rdy = 0; obs_post_vld = 1;
        alu_done_i = 0; alu_busy_i = 0; wb_ready_i = 0; alu_out = '0;
        cyc = 0;
        while (in_ready_o !== 1'b1 && cyc < 50) begin
            @(negedge clk); #1; cyc++;
        end
        in_valid_i = 1; in_opcode_i = i_opc; in_fun3_i = i_f3; in_fun7_i = i_f7;
        in_rs1_i = i_rs1; in_rs2_i = i_rs2; in_imm_i = i_imm; in_rd_i = i_rd;
        @(posedge clk); #1;
        in_valid_i = 0; in_opcode_i = 7'($urandom); in_fun3_i = 3'($urandom);
        in_fun7_i = 7'($urandom); in_rs1_i = $urandom; in_rs2_i = $urandom;
        in_imm_i = $urandom; in_rd_i = 5'($urandom);
        started = 0; wait_left = 0; cyc = 0;
        while (!obs_got_wb && cyc < 100) begin
            @(negedge clk); cyc++;
            alu_busy_i = (cyc <= busy_n);
            if (started) begin
                if (done_dly >= 0 && wait_left == 0) begin
                    alu_done_i = 1; alu_res_i = alu_out;
                    alu_zero_i = (alu_out == 0); alu_neg_i = alu_out[31];
                end else begin
                    alu_done_i = 0; alu_res_i = $urandom;
                    alu_zero_i = 1'($urandom); alu_neg_i = 1'($urandom);
                    if (wait_left > 0) wait_left--;
                end
            end
            #1;
            if (in_ready_o !== 1'b0) obs_rdy_bad = 1;
            if (alu_start_o === 1'b1) begin
                obs_starts++;
                if (alu_busy_i) obs_busy_viol = 1;
                if (!started) begin
                    started = 1; wait_left = done_dly;
                    obs_f3 = alu_fun3_o; obs_f7 = alu_fun7_o;
                    obs_rs1 = alu_rs1_o; obs_rs2 = alu_rs2_o;
                    alu_out = m_alu(alu_fun3_o, alu_fun7_o, alu_rs1_o, alu_rs2_o);
                end
            end
            if (started && wb_valid_o !== 1'b1 &&
                {alu_fun3_o, alu_fun7_o, alu_rs1_o, alu_rs2_o} !== {obs_f3, obs_f7, obs_rs1, obs_rs2})
                obs_hold_bad = 1;
            if (wb_valid_o === 1'b1) begin
                obs_got_wb = 1; obs_lat = cyc;
                obs_data = wb_data_o; obs_rd = wb_rd_o; obs_we = wb_we_o;
                obs_zero = wb_zero_o; obs_neg = wb_neg_o; obs_err = wb_err_o;
            end
        end
        if (obs_got_wb) begin
            for (int s = 0; s < stall_n; s++) begin
                @(negedge clk); #1;
                if (wb_valid_o !== 1'b1 || in_ready_o !== 1'b0 || wb_data_o !== obs_data ||
                    wb_rd_o !== obs_rd || wb_we_o !== obs_we || wb_err_o !== obs_err ||
                    wb_zero_o !== obs_zero || wb_neg_o !== obs_neg)
                    obs_stall_bad = 1;
            end
            wb_ready_i = 1;
            @(posedge clk); #1;
            wb_ready_i = 0; alu_done_i = 0; alu_busy_i = 0;
            obs_post_rdy = in_ready_o; obs_post_vld = wb_valid_o;
            @(negedge clk); #1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_i = 1; in_valid_i = 0; wb_ready_i = 0; alu_busy_i = 0; alu_done_i = 0;
        alu_res_i = '0; alu_zero_i = 0; alu_neg_i = 0;
        in_opcode_i = '0; in_fun3_i = '0; in_fun7_i = '0;
        in_rs1_i = '0; in_rs2_i = '0; in_imm_i = '0; in_rd_i = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({in_ready_o, alu_start_o, wb_valid_o, wb_we_o, wb_err_o} !== 5'b10000) begin
            bad++; $display("FAIL reset_ctrl got=%b want=10000",
                            {in_ready_o, alu_start_o, wb_valid_o, wb_we_o, wb_err_o});
        end
        total++;
        if ({alu_fun3_o, alu_fun7_o, alu_rs1_o, alu_rs2_o, wb_rd_o, wb_data_o, wb_zero_o, wb_neg_o} !== '0) begin
            bad++; $display("FAIL reset_data got rs1=%h rs2=%h data=%h rd=%0d want all zero",
                            alu_rs1_o, alu_rs2_o, wb_data_o, wb_rd_o);
        end
        @(negedge clk); reset_i = 0; #1;
    endtask

    task automatic test_add();
        i_opc = OPC_OP; i_f3 = 3'd0; i_f7 = 7'd0; i_rs1 = 32'd5; i_rs2 = 32'd7;
        i_imm = 32'h0000_0abc; i_rd = 5'd3;
        do_op(0, 0, 0);
        total++;
        if (obs_rs2 !== 32'd7 || obs_rs1 !== 32'd5) begin
            bad++; $display("FAIL add_operands got rs1=%0d rs2=%0d want 5 7", obs_rs1, obs_rs2);
        end
        total++;
        if (obs_starts !== 1) begin bad++; $display("FAIL add_starts got=%0d want=1", obs_starts); end
        total++;
        if (obs_data !== 32'd12 || obs_rd !== 5'd3 || obs_we !== 1'b1 || obs_err !== 1'b0) begin
            bad++; $display("FAIL add_wb got data=%0d rd=%0d we=%b err=%b want 12 3 1 0",
                            obs_data, obs_rd, obs_we, obs_err);
        end
        total++;
        if (obs_lat !== 3) begin bad++; $display("FAIL add_latency got=%0d want=3", obs_lat); end
        total++;
        if (obs_post_rdy !== 1'b1 || obs_post_vld !== 1'b0) begin
            bad++; $display("FAIL add_return_idle got rdy=%b vld=%b want 1 0", obs_post_rdy, obs_post_vld);
        end
    endtask

    task automatic test_srai();
        i_opc = OPC_OPIMM; i_f3 = 3'd5; i_f7 = 7'h55; i_rs1 = 32'h8000_0000; i_rs2 = 32'h1234_5678;
        i_imm = 32'h0000_0405; i_rd = 5'd9;
        do_op(0, 2, 0);
        total++;
        if (obs_f7 !== 7'h20 || obs_rs2 !== 32'd5 || obs_f3 !== 3'd5) begin
            bad++; $display("FAIL srai_operands got f3=%0d f7=%h rs2=%h want 5 20 5", obs_f3, obs_f7, obs_rs2);
        end
        total++;
        if (obs_data !== 32'hFC00_0000 || obs_neg !== 1'b1 || obs_zero !== 1'b0 || obs_we !== 1'b1) begin
            bad++; $display("FAIL srai_wb got data=%h neg=%b zero=%b we=%b want fc000000 1 0 1",
                            obs_data, obs_neg, obs_zero, obs_we);
        end
        total++;
        if (obs_lat !== 5) begin bad++; $display("FAIL srai_latency got=%0d want=5", obs_lat); end
    endtask

    task automatic test_sll_rd0();
        i_opc = OPC_OP; i_f3 = 3'd1; i_f7 = 7'd0; i_rs1 = 32'h0000_0003; i_rs2 = 32'h0000_0021;
        i_imm = '0; i_rd = 5'd0;
        do_op(0, 0, 0);
        total++;
        if (obs_rs2 !== 32'd1) begin bad++; $display("FAIL sll_mask got rs2=%h want=1", obs_rs2); end
        total++;
        if (obs_got_wb !== 1'b1 || obs_we !== 1'b0 || obs_data !== 32'd6) begin
            bad++; $display("FAIL sll_rd0 got vld=%b we=%b data=%h want 1 0 6", obs_got_wb, obs_we, obs_data);
        end
    endtask

    task automatic test_timeout();
        i_opc = OPC_OP; i_f3 = 3'd4; i_f7 = 7'd0; i_rs1 = $urandom; i_rs2 = $urandom;
        i_imm = '0; i_rd = 5'd7;
        do_op(0, -1, 0);
        total++;
        if (obs_err !== 1'b1 || obs_data !== 32'd0 || obs_we !== 1'b0) begin
            bad++; $display("FAIL timeout_wb got err=%b data=%h we=%b want 1 0 0", obs_err, obs_data, obs_we);
        end
        total++;
        if (obs_lat !== 2 + TIMEOUT) begin
            bad++; $display("FAIL timeout_latency got=%0d want=%0d", obs_lat, 2 + TIMEOUT);
        end
        total++;
        if (obs_post_rdy !== 1'b1) begin bad++; $display("FAIL timeout_idle got rdy=%b want=1", obs_post_rdy); end
        // done on the last permitted WAIT cycle wins over the timeout
        do_op(0, TIMEOUT - 1, 0);
        total++;
        if (obs_err !== 1'b0 || obs_data !== (i_rs1 ^ i_rs2) || obs_lat !== 2 + TIMEOUT) begin
            bad++; $display("FAIL done_at_limit got err=%b data=%h lat=%0d want 0 %h %0d",
                            obs_err, obs_data, obs_lat, i_rs1 ^ i_rs2, 2 + TIMEOUT);
        end
        do_op(0, TIMEOUT, 0);
        total++;
        if (obs_err !== 1'b1 || obs_data !== 32'd0) begin
            bad++; $display("FAIL done_past_limit got err=%b data=%h want 1 0", obs_err, obs_data);
        end
    endtask

    task automatic test_stall_busy();
        i_opc = OPC_OP; i_f3 = 3'd6; i_f7 = 7'd0; i_rs1 = 32'hF0F0_0000; i_rs2 = 32'h0000_0F0F;
        i_imm = '0; i_rd = 5'd17;
        do_op(3, 1, 5);
        total++;
        if (obs_busy_viol !== 1'b0 || obs_starts !== 1) begin
            bad++; $display("FAIL busy_start got viol=%b starts=%0d want 0 1", obs_busy_viol, obs_starts);
        end
        total++;
        if (obs_lat !== 7) begin bad++; $display("FAIL busy_latency got=%0d want=7", obs_lat); end
        total++;
        if (obs_stall_bad !== 1'b0 || obs_hold_bad !== 1'b0 || obs_rdy_bad !== 1'b0) begin
            bad++; $display("FAIL stall_hold got stall=%b hold=%b rdy=%b want 0 0 0",
                            obs_stall_bad, obs_hold_bad, obs_rdy_bad);
        end
        total++;
        if (obs_data !== 32'hF0F0_0F0F || obs_post_rdy !== 1'b1) begin
            bad++; $display("FAIL stall_data got data=%h rdy=%b want f0f00f0f 1", obs_data, obs_post_rdy);
        end
    endtask

    task automatic test_reset_mid_op();
        bit seen;
        in_valid_i = 1; in_opcode_i = OPC_OP; in_fun3_i = 3'd0; in_fun7_i = 7'd0;
        in_rs1_i = 32'd1; in_rs2_i = 32'd2; in_imm_i = '0; in_rd_i = 5'd4;
        alu_busy_i = 0; alu_done_i = 0; wb_ready_i = 1;
        @(posedge clk); #1; in_valid_i = 0;
        repeat (3) begin @(negedge clk); end
        #1;
        reset_i = 1;
        @(posedge clk); #1; reset_i = 0;
        total++;
        if (in_ready_o !== 1'b1 || wb_valid_o !== 1'b0) begin
            bad++; $display("FAIL reset_mid_idle got rdy=%b vld=%b want 1 0", in_ready_o, wb_valid_o);
        end
        seen = 0; alu_done_i = 1; alu_res_i = 32'd3;
        repeat (20) begin
            @(negedge clk); #1;
            if (wb_valid_o !== 1'b0 || alu_start_o !== 1'b0) seen = 1;
        end
        alu_done_i = 0; wb_ready_i = 0;
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL reset_mid_no_wb got seen=%b want=0", seen); end
    endtask

    task automatic test_back_to_back_illegal();
        i_opc = 7'h33; i_f3 = 3'd0; i_f7 = 7'h20; i_rs1 = 32'd100; i_rs2 = 32'd40;
        i_imm = '0; i_rd = 5'd12;
        do_op(0, 0, 0);
        total++;
        if (obs_data !== 32'd60 || obs_err !== 1'b0 || obs_we !== 1'b1) begin
            bad++; $display("FAIL sub_wb got data=%0d err=%b we=%b want 60 0 1", obs_data, obs_err, obs_we);
        end
        i_opc = 7'h63; i_rd = 5'd13;
        do_op(0, 0, 0);
        total++;
        if (obs_err !== 1'b1 || obs_we !== 1'b0 || obs_data !== 32'd0 || obs_starts !== 0) begin
            bad++; $display("FAIL illegal_wb got err=%b we=%b data=%h starts=%0d want 1 0 0 0",
                            obs_err, obs_we, obs_data, obs_starts);
        end
        total++;
        if (obs_lat !== 1 || obs_post_rdy !== 1'b1) begin
            bad++; $display("FAIL illegal_flow got lat=%0d rdy=%b want 1 1", obs_lat, obs_post_rdy);
        end
    endtask

    task automatic test_random();
        int busy_n, done_dly, stall_n, sel, exp_lat;
        logic [31:0] r, e_rs2, e_data;
        logic [6:0]  e_f7;
        bit legal;
        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 9);
            i_opc = (sel < 4) ? OPC_OP : (sel < 8) ? OPC_OPIMM : 7'h03 + 7'($urandom_range(0, 1) * 7'h60);
            i_f3 = 3'($urandom);
            i_f7 = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
            i_rs1 = $urandom; i_rs2 = $urandom;
            r = $urandom; i_imm = {{20{r[11]}}, r[11:0]};
            i_rd = 5'($urandom);
            busy_n = $urandom_range(0, 2); done_dly = $urandom_range(0, 4); stall_n = $urandom_range(0, 2);
            do_op(busy_n, done_dly, stall_n);
            legal = m_legal(i_opc);
            e_rs2 = m_rs2(i_opc, i_f3, i_rs2, i_imm);
            e_f7  = m_f7(i_opc, i_f3, i_f7, i_imm);
            e_data = legal ? m_alu(i_f3, e_f7, i_rs1, e_rs2) : 32'd0;
            exp_lat = legal ? 3 + busy_n + done_dly : 1;
            total++;
            if (legal && {obs_f3, obs_f7, obs_rs1, obs_rs2} !== {i_f3, e_f7, i_rs1, e_rs2}) begin
                bad++; $display("FAIL rnd_operands n=%0d got f3=%0d f7=%h rs1=%h rs2=%h want %0d %h %h %h",
                                n, obs_f3, obs_f7, obs_rs1, obs_rs2, i_f3, e_f7, i_rs1, e_rs2);
            end
            total++;
            if (obs_starts !== (legal ? 1 : 0) || obs_lat !== exp_lat || obs_busy_viol !== 1'b0) begin
                bad++; $display("FAIL rnd_flow n=%0d got starts=%0d lat=%0d viol=%b want %0d %0d 0",
                                n, obs_starts, obs_lat, obs_busy_viol, legal ? 1 : 0, exp_lat);
            end
            total++;
            if (obs_data !== e_data || obs_err !== !legal || obs_rd !== i_rd ||
                obs_we !== (legal && i_rd != 5'd0)) begin
                bad++; $display("FAIL rnd_wb n=%0d got data=%h err=%b rd=%0d we=%b want %h %b %0d %b",
                                n, obs_data, obs_err, obs_rd, obs_we, e_data, !legal, i_rd, legal && i_rd != 5'd0);
            end
            total++;
            if (legal && (obs_zero !== (e_data == 32'd0) || obs_neg !== e_data[31])) begin
                bad++; $display("FAIL rnd_flags n=%0d got zero=%b neg=%b want %b %b",
                                n, obs_zero, obs_neg, e_data == 32'd0, e_data[31]);
            end
            total++;
            if (obs_hold_bad || obs_stall_bad || obs_rdy_bad || obs_post_rdy !== 1'b1) begin
                bad++; $display("FAIL rnd_hold n=%0d got hold=%b stall=%b rdy=%b post=%b want 0 0 0 1",
                                n, obs_hold_bad, obs_stall_bad, obs_rdy_bad, obs_post_rdy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_srai();
        test_sll_rd0();
        test_timeout();
        test_stall_busy();
        test_reset_mid_op();
        test_back_to_back_illegal();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
